console_writer: RTL and testbench



---
 rtl/console_writer.sv | 181 ++++++++++++++++++
 tb/tb_console_writer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/console_writer.sv
// Text-write controller for the console VRAM: accepts character codes, tracks a
// screenW x screenH cursor and issues VRAM writes only during video blanking.
module console_writer #(
    parameter int unsigned screenW    = 40,
    parameter int unsigned screenH    = 30,
    parameter logic [7:0]  blank_char = 8'h20
) (
    input  logic        px_clk,
    input  logic        reset_n,
    input  logic [25:0] RGBStr_i,
    input  logic [7:0]  char_i,
    input  logic        char_valid_i,
    output logic        char_ready_o,
    output logic        vram_we_o,
    output logic [10:0] vram_waddr_o,
    output logic [7:0]  vram_wdata_o,
    output logic [5:0]  cursor_x_o,
    output logic [4:0]  cursor_y_o,
    output logic        busy_o
);

    localparam logic [10:0] LastCell = 11'(screenW * screenH - 1);
    localparam logic [10:0] LastCol  = 11'(screenW - 1);
    localparam logic [5:0]  LastX    = 6'(screenW - 1);
    localparam logic [4:0]  LastY    = 5'(screenH - 1);

    typedef enum logic [1:0] {StClrAll, StIdle, StWrite, StClrLine} state_e;

    state_e      state_q, state_d;
    logic [10:0] clr_cnt_q, clr_cnt_d;
    logic [5:0]  cursor_x_q, cursor_x_d;
    logic [4:0]  cursor_y_q, cursor_y_d;
    logic [7:0]  wr_char_q, wr_char_d;
    logic        wr_bs_q, wr_bs_d;
    logic        vram_we_q, vram_we_d;
    logic [10:0] vram_waddr_q, vram_waddr_d;
    logic [7:0]  vram_wdata_q, vram_wdata_d;

    logic        active;
    logic        accept;
    logic        printable;
    logic [4:0]  next_y;
    logic [10:0] row_base;
    logic [10:0] cur_addr;
    logic [24:0] unused_rgb;

    assign active     = RGBStr_i[0];
    assign unused_rgb = RGBStr_i[25:1];
    assign accept     = char_valid_i && char_ready_o;
    assign printable  = (char_i >= 8'h20) && (char_i <= 8'h7E);
    assign next_y     = (cursor_y_q == LastY) ? 5'd0 : cursor_y_q + 5'd1;
    assign row_base   = 11'(cursor_y_q) * 11'(screenW);
    assign cur_addr   = row_base + 11'(cursor_x_q);

    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StClrAll;
            clr_cnt_q    <= '0;
            cursor_x_q   <= '0;
            cursor_y_q   <= '0;
            wr_char_q    <= '0;
            wr_bs_q      <= 1'b0;
            vram_we_q    <= 1'b0;
            vram_waddr_q <= '0;
            vram_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            cursor_x_q   <= cursor_x_d;
            cursor_y_q   <= cursor_y_d;
            wr_char_q    <= wr_char_d;
            wr_bs_q      <= wr_bs_d;
            vram_we_q    <= vram_we_d;
            vram_waddr_q <= vram_waddr_d;
            vram_wdata_q <= vram_wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        cursor_x_d   = cursor_x_q;
        cursor_y_d   = cursor_y_q;
        wr_char_d    = wr_char_q;
        wr_bs_d      = wr_bs_q;
        vram_we_d    = 1'b0;
        vram_waddr_d = vram_waddr_q;
        vram_wdata_d = vram_wdata_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (printable) begin
                        wr_char_d = char_i;
                        wr_bs_d   = 1'b0;
                        state_d   = StWrite;
                    end else begin
                        case (char_i)
                            8'h0D: cursor_x_d = '0;
                            8'h0A: begin
                                cursor_x_d = '0;
                                cursor_y_d = next_y;
                                clr_cnt_d  = '0;
                                state_d    = StClrLine;
                            end
                            8'h08: begin
                                // Cursor moves back first so the write lands on the new cell.
                                if (cursor_x_q != 6'd0) begin
                                    cursor_x_d = cursor_x_q - 6'd1;
                                    wr_bs_d    = 1'b1;
                                    state_d    = StWrite;
                                end
                            end
                            8'h0C: begin
                                cursor_x_d = '0;
                                cursor_y_d = '0;
                                clr_cnt_d  = '0;
                                state_d    = StClrAll;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            StWrite: begin
                if (!active) begin
                    vram_we_d    = 1'b1;
                    vram_waddr_d = cur_addr;
                    vram_wdata_d = wr_bs_q ? blank_char : wr_char_q;
                    if (wr_bs_q) begin
                        state_d = StIdle;
                    end else if (cursor_x_q == LastX) begin
                        cursor_x_d = '0;
                        cursor_y_d = next_y;
                        clr_cnt_d  = '0;
                        state_d    = StClrLine;
                    end else begin
                        cursor_x_d = cursor_x_q + 6'd1;
                        state_d    = StIdle;
                    end
                end
            end
            StClrLine: begin
                if (!active) begin
                    vram_we_d    = 1'b1;
                    vram_waddr_d = row_base + clr_cnt_q;
                    vram_wdata_d = blank_char;
                    if (clr_cnt_q == LastCol) begin
                        state_d = StIdle;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 11'd1;
                    end
                end
            end
            StClrAll: begin
                if (!active) begin
                    vram_we_d    = 1'b1;
                    vram_waddr_d = clr_cnt_q;
                    vram_wdata_d = blank_char;
                    if (clr_cnt_q == LastCell) begin
                        state_d = StIdle;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 11'd1;
                    end
                end
            end
            default: state_d = StClrAll;
        endcase
    end

    always_comb begin
        char_ready_o = (state_q == StIdle);
        busy_o       = (state_q == StClrAll) || (state_q == StClrLine);
        vram_we_o    = vram_we_q;
        vram_waddr_o = vram_waddr_q;
        vram_wdata_o = vram_wdata_q;
        cursor_x_o   = cursor_x_q;
        cursor_y_o   = cursor_y_q;
    end

endmodule

// File: tb/tb_console_writer.sv
// Bench for console_writer: a cursor/write-list model predicts every VRAM write,
// directed sequences pin latency, cursor positions and reset behaviour.
module tb_console_writer;

    logic        px_clk;
    logic        reset_n;
    logic [25:0] RGBStr_i;
    logic [7:0]  char_i;
    logic        char_valid_i;
    logic        char_ready_o;
    logic        vram_we_o;
    logic [10:0] vram_waddr_o;
    logic [7:0]  vram_wdata_o;
    logic [5:0]  cursor_x_o;
    logic [4:0]  cursor_y_o;
    logic        busy_o;

    console_writer dut (
        .px_clk       (px_clk),
        .reset_n      (reset_n),
        .RGBStr_i     (RGBStr_i),
        .char_i       (char_i),
        .char_valid_i (char_valid_i),
        .char_ready_o (char_ready_o),
        .vram_we_o    (vram_we_o),
        .vram_waddr_o (vram_waddr_o),
        .vram_wdata_o (vram_wdata_o),
        .cursor_x_o   (cursor_x_o),
        .cursor_y_o   (cursor_y_o),
        .busy_o       (busy_o)
    );

    initial begin
        px_clk = 1'b0;
        forever #5 px_clk = ~px_clk;
    end

    int checks   = 0;
    int failures = 0;

    // Model: expected writes as (addr << 8) | data, plus the cursor.
    int exp_q[$];
    int mx = 0;
    int my = 0;
    int we_count = 0;
    logic [10:0] last_addr = '0;
    logic [7:0]  last_data = '0;
    logic        prev_active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic model_clear_all();
        for (int i = 0; i < 1200; i++) exp_q.push_back((i << 8) | 'h20);
    endtask

    task automatic model_row_adv();
        my = (my + 1) % 30;
        for (int i = 0; i < 40; i++) exp_q.push_back(((my * 40 + i) << 8) | 'h20);
    endtask

    task automatic model_char(input logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            exp_q.push_back(((my * 40 + mx) << 8) | int'(c));
            if (mx == 39) begin
                mx = 0;
                model_row_adv();
            end else begin
                mx++;
            end
        end else if (c == 8'h0D) begin
            mx = 0;
        end else if (c == 8'h0A) begin
            mx = 0;
            model_row_adv();
        end else if (c == 8'h08) begin
            if (mx > 0) begin
                mx--;
                exp_q.push_back(((my * 40 + mx) << 8) | 'h20);
            end
        end else if (c == 8'h0C) begin
            mx = 0;
            my = 0;
            model_clear_all();
        end
    endtask

    always @(posedge px_clk) prev_active <= RGBStr_i[0];

    // Every write strobe is checked against the head of the model's write list.
    always @(negedge px_clk) begin
        if (reset_n === 1'b1 && vram_we_o === 1'b1) begin
            int e;
            we_count++;
            last_addr = vram_waddr_o;
            last_data = vram_wdata_o;
            check("we_after_active", 32'(prev_active), 32'd0);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: addr %0d data 0x%0h with no write expected",
                         vram_waddr_o, vram_wdata_o);
            end else begin
                e = exp_q.pop_front();
                check("waddr", 32'(vram_waddr_o), 32'(e >> 8));
                check("wdata", 32'(vram_wdata_o), 32'(e & 255));
            end
        end
    end

    task automatic send(input logic [7:0] c);
        int n = 0;
        @(negedge px_clk);
        while (char_ready_o !== 1'b1 && n < 3000) begin
            @(negedge px_clk);
            n++;
        end
        if (char_ready_o !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: ready stayed low, code 0x%0h not sent", c);
        end else begin
            char_i       = c;
            char_valid_i = 1'b1;
            @(posedge px_clk);
            #1;
            char_valid_i = 1'b0;
            model_char(c);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        bit idle = 0;
        while (!idle && n < budget) begin
            @(negedge px_clk);
            #1;
            n++;
            idle = (char_ready_o === 1'b1) && (exp_q.size() == 0);
        end
        checks++;
        if (!idle) begin
            failures++;
            $display("FAIL %s: not idle after %0d cycles, %0d writes outstanding",
                     name, n, exp_q.size());
        end
    endtask

    task automatic check_cursor(input string name, input int x, input int y);
        check({name, "_x"}, 32'(cursor_x_o), 32'(x));
        check({name, "_y"}, 32'(cursor_y_o), 32'(y));
        check({name, "_model_x"}, 32'(mx), 32'(x));
        check({name, "_model_y"}, 32'(my), 32'(y));
    endtask

    initial begin
        int n;
        int lowcyc;
        int wes;
        int snap;

        reset_n      = 1'b1;
        RGBStr_i     = '0;
        char_i       = '0;
        char_valid_i = 1'b0;
        #2 reset_n = 1'b0;
        #2;
        check("rst_we", 32'(vram_we_o), 32'd0);
        check("rst_waddr", 32'(vram_waddr_o), 32'd0);
        check("rst_wdata", 32'(vram_wdata_o), 32'd0);
        check("rst_ready", 32'(char_ready_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd1);
        check("rst_cx", 32'(cursor_x_o), 32'd0);
        check("rst_cy", 32'(cursor_y_o), 32'd0);
        repeat (2) @(negedge px_clk);

        // Initial clear: 1200 back-to-back writes, then idle.
        model_clear_all();
        @(negedge px_clk);
        reset_n = 1'b1;
        n = 0;
        while (char_ready_o !== 1'b1 && n < 1500) begin
            @(negedge px_clk);
            n++;
        end
        check("init_cycles", 32'(n), 32'd1200);
        #1;
        check("init_busy", 32'(busy_o), 32'd0);
        check("init_queue", 32'(exp_q.size()), 32'd0);
        check_cursor("init_cursor", 0, 0);

        // 'A' during blanking: write lands one edge after acceptance.
        send(8'h41);
        @(negedge px_clk);
        check("a_lat_we0", 32'(vram_we_o), 32'd0);
        @(negedge px_clk);
        check("a_we", 32'(vram_we_o), 32'd1);
        check("a_addr", 32'(vram_waddr_o), 32'd0);
        check("a_data", 32'(vram_wdata_o), 32'h41);
        check("a_cx", 32'(cursor_x_o), 32'd1);
        @(negedge px_clk);
        check("a_we_once", 32'(vram_we_o), 32'd0);
        wait_idle("a_idle", 10);

        // Unassigned control code is swallowed.
        snap = we_count;
        send(8'h7F);
        repeat (4) @(negedge px_clk);
        check("ign_nowrite", 32'(we_count), 32'(snap));
        check_cursor("ign_cursor", 1, 0);

        // Write held off by active video.
        RGBStr_i = 26'd1;
        snap = we_count;
        send(8'h42);
        repeat (100) @(negedge px_clk);
        check("active_hold", 32'(we_count), 32'(snap));
        check("active_ready", 32'(char_ready_o), 32'd0);
        RGBStr_i = 26'd0;
        wait_idle("active_idle", 10);
        check("active_one_write", 32'(we_count), 32'(snap + 1));
        check("active_addr", 32'(last_addr), 32'd1);
        check_cursor("active_cursor", 2, 0);

        // Form feed: full clear and home.
        send(8'h0C);
        @(negedge px_clk);
        check("ff_busy", 32'(busy_o), 32'd1);
        wait_idle("ff_idle", 1300);
        check_cursor("ff_cursor", 0, 0);

        // Walk to (39,29), then 'Z' wraps to row 0 and clears it.
        for (int i = 0; i < 29; i++) send(8'h0A);
        for (int i = 0; i < 39; i++) send(8'h61 + 8'(i % 26));
        wait_idle("walk_idle", 200);
        check_cursor("walk_cursor", 39, 29);
        send(8'h5A);
        lowcyc = 0;
        wes = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge px_clk);
            if (vram_we_o === 1'b1) wes++;
            if (char_ready_o === 1'b1) break;
            lowcyc++;
        end
        check("z_ready_low", 32'(lowcyc), 32'd41);
        check("z_writes", 32'(wes), 32'd41);
        #1;
        check("z_queue", 32'(exp_q.size()), 32'd0);
        check("z_last_addr", 32'(last_addr), 32'd39);
        check_cursor("z_cursor", 0, 0);

        // Backspace at (5,2) blanks column 4.
        send(8'h0A);
        send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h30 + 8'(i));
        wait_idle("bs_setup", 200);
        check_cursor("bs_pre", 5, 2);
        send(8'h08);
        wait_idle("bs_idle", 10);
        check("bs_addr", 32'(last_addr), 32'd84);
        check("bs_data", 32'(last_data), 32'h20);
        check_cursor("bs_cursor", 4, 2);

        // Backspace at column 0 is a no-op.
        send(8'h0D);
        snap = we_count;
        send(8'h08);
        repeat (5) @(negedge px_clk);
        check("bs0_nowrite", 32'(we_count), 32'(snap));
        check_cursor("bs0_cursor", 0, 2);

        // CR then LF from (7,3).
        send(8'h0A);
        for (int i = 0; i < 7; i++) send(8'h41 + 8'(i));
        wait_idle("crlf_setup", 200);
        check_cursor("crlf_pre", 7, 3);
        snap = we_count;
        send(8'h0D);
        repeat (5) @(negedge px_clk);
        check("cr_nowrite", 32'(we_count), 32'(snap));
        check_cursor("cr_cursor", 0, 3);
        send(8'h0A);
        wait_idle("lf_idle", 100);
        check("lf_writes", 32'(we_count), 32'(snap + 40));
        check("lf_last_addr", 32'(last_addr), 32'd199);
        check_cursor("lf_cursor", 0, 4);

        // Reset pulse in the middle of a line clear.
        send(8'h0A);
        repeat (10) @(negedge px_clk);
        #2;
        check("mid_we_before", 32'(vram_we_o), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_we_async", 32'(vram_we_o), 32'd0);
        check("mid_busy", 32'(busy_o), 32'd1);
        check("mid_ready", 32'(char_ready_o), 32'd0);
        check("mid_cx", 32'(cursor_x_o), 32'd0);
        check("mid_cy", 32'(cursor_y_o), 32'd0);
        exp_q.delete();
        mx = 0;
        my = 0;
        model_clear_all();
        @(negedge px_clk);
        reset_n = 1'b1;
        snap = we_count;
        @(negedge px_clk);
        #1;
        check("restart_we", 32'(we_count), 32'(snap + 1));
        check("restart_addr", 32'(last_addr), 32'd0);
        wait_idle("restart_idle", 1300);
        check("restart_writes", 32'(we_count), 32'(snap + 1200));
        check_cursor("restart_cursor", 0, 0);

        repeat (3) @(negedge px_clk);
        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
